// File: rtl/sw_pkg.sv
// Shared stopwatch definitions: mode encodings seen on the FSM's 2-bit
// state output, time-field limits and widths, and a small mode helper.
package sw_pkg;

    // Mode encodings driven by the stopwatch FSM and decoded by the counter.
    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_LAP   = 2'b10,
        ST_PAUSE = 2'b11
    } sw_state_e;

    // Highest legal value of each time field before it rolls to zero.
    localparam int CS_MAX = 99;
    localparam int SM_MAX = 59;

    // Field widths: centiseconds need 7 bits, seconds/minutes need 6.
    localparam int CS_W = 7;
    localparam int SM_W = 6;

    // True for the modes in which the live count advances.
    function automatic logic is_counting(input sw_state_e st);
        return (st == ST_RUN) || (st == ST_LAP);
    endfunction

endpackage : sw_pkg

// File: rtl/sw_prescaler.sv
// Divides the system clock down to one tick every CLK_DIV cycles.
// clr forces the phase back to zero and wins over en; while en is low
// the partial phase is kept so a resumed run continues where it stopped.
module sw_prescaler #(
    parameter int CLK_DIV = 500000,
    parameter int DIV_W   = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] PRE_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] pre;

    // Tick is valid for the cycle in which the phase sits on its last value
    // and the counter is enabled, so the edge that wraps pre also counts.
    assign tick = en && !clr && (pre == PRE_LAST);

    // Phase register: clear has priority, otherwise advance and wrap when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (en) begin
            if (pre == PRE_LAST) begin
                pre <= '0;
            end else begin
                pre <= pre + PRE_ONE;
            end
        end
    end

endmodule : sw_prescaler

// File: rtl/sw_time_counter.sv
// Stopwatch time base and counting stage. Keeps a live mm:ss.cc count
// that clears, runs or holds according to the FSM mode, plus a display
// copy that freezes while in LAP.
//
// The mode input is a plain level: it is sampled on every rising edge and
// takes effect on that same edge; there is no valid/ready exchange.
module sw_time_counter
    import sw_pkg::*;
#(
    parameter int CLK_DIV = 500000,
    parameter int DIV_W   = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      state,
    output logic [CS_W-1:0] disp_cs,
    output logic [SM_W-1:0] disp_s,
    output logic [SM_W-1:0] disp_m,
    output logic            running,
    output logic            wrap
);

    localparam logic [CS_W-1:0] CS_LAST = CS_W'(CS_MAX);
    localparam logic [SM_W-1:0] SM_LAST = SM_W'(SM_MAX);
    localparam logic [CS_W-1:0] CS_ONE  = CS_W'(1);
    localparam logic [SM_W-1:0] SM_ONE  = SM_W'(1);

    sw_state_e st;
    logic      counting;
    logic      clear;
    logic      tick;

    // Live count and its value after the current edge.
    logic [CS_W-1:0] cs,     cs_nxt;
    logic [SM_W-1:0] s,      s_nxt;
    logic [SM_W-1:0] m,      m_nxt;
    logic            roll_nxt;

    assign st       = sw_state_e'(state);
    assign counting = is_counting(st);
    assign clear    = (st == ST_STOP);

    sw_prescaler #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (counting),
        .clr   (clear),
        .tick  (tick)
    );

    // Next live value: STOP clears, a tick increments with the full
    // cs -> s -> m carry chain resolved in one edge, anything else holds.
    always_comb begin
        cs_nxt   = cs;
        s_nxt    = s;
        m_nxt    = m;
        roll_nxt = 1'b0;
        if (clear) begin
            cs_nxt = '0;
            s_nxt  = '0;
            m_nxt  = '0;
        end else if (tick) begin
            if (cs == CS_LAST) begin
                cs_nxt = '0;
                if (s == SM_LAST) begin
                    s_nxt = '0;
                    if (m == SM_LAST) begin
                        m_nxt    = '0;
                        roll_nxt = 1'b1;
                    end else begin
                        m_nxt = m + SM_ONE;
                    end
                end else begin
                    s_nxt = s + SM_ONE;
                end
            end else begin
                cs_nxt = cs + CS_ONE;
            end
        end
    end

    // Live count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs <= '0;
            s  <= '0;
            m  <= '0;
        end else begin
            cs <= cs_nxt;
            s  <= s_nxt;
            m  <= m_nxt;
        end
    end

    // Display copy: follows the post-edge live value except while in LAP,
    // where it keeps the value captured on the last non-LAP edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_cs <= '0;
            disp_s  <= '0;
            disp_m  <= '0;
        end else if (st != ST_LAP) begin
            disp_cs <= cs_nxt;
            disp_s  <= s_nxt;
            disp_m  <= m_nxt;
        end
    end

    // Status flags: running mirrors the mode one cycle late; wrap is a
    // single-cycle pulse after the 59:59.99 -> 00:00.00 rollover edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            running <= counting;
            wrap    <= roll_nxt;
        end
    end

endmodule : sw_time_counter

// File: doc/sw_time_counter.md
# sw_time_counter

Stopwatch time-base and counting stage, fed directly by the stopwatch mode FSM's 2-bit `state` output. It divides the system clock down to 10 ms ticks and keeps a live centisecond/second/minute count that clears, runs or holds according to the FSM mode. It also keeps a display copy that freezes while in LAP, so the display driver shows the lap time while the live count continues.

## Interface
- `CLK_DIV`, default 500000: clock cycles per centisecond tick (50 MHz → 10 ms); legal range ≥ 2.
- `DIV_W`, default 19: prescaler width; must satisfy 2^DIV_W ≥ CLK_DIV.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `state`  in  2  mode from the FSM: 00 STOP, 01 RUN, 10 LAP, 11 PAUSE.
- `disp_cs`  out  7  displayed centiseconds, 0–99.
- `disp_s`  out  6  displayed seconds, 0–59.
- `disp_m`  out  6  displayed minutes, 0–59.
- `running`  out  1  high when the live count advances (RUN or LAP).
- `wrap`  out  1  one-cycle pulse when the live count rolls 59:59.99 → 00:00.00.

## Operation
- Live registers `cs`, `s` and `m` are internal. The prescaler `pre` is 0..CLK_DIV-1.
- Reset (`rst_n` low, any time, including mid-count): `pre`, `cs`, `s`, `m`, all `disp_*`, `running` and `wrap` are forced to 0 immediately. No sync-release stage is included; the reset synchronizer is at top level.
- STOP (00):
  - `pre`, `cs`, `s` and `m` are cleared to 0 on the next edge.
  - The display tracks the live count.
- RUN (01):
  - `pre` increments each cycle. At CLK_DIV-1 it wraps to 0 and asserts an internal `tick` for that cycle.
  - On `tick`, `cs` increments.
  - `cs` = 99 → 0 with carry into `s`.
  - `s` = 59 → 0 with carry into `m`.
  - `m` = 59 → 0 and `wrap` pulses.
  - All carries resolve in the same edge.
- LAP (10):
  - Live counting is identical to RUN.
  - The `disp_*` registers hold their value.
- PAUSE (11):
  - `pre`, `cs`, `s` and `m` hold.
  - The display tracks the live count (static).
- Display update: every edge where `state` ≠ LAP, `disp_*` ← the live value as it will be after this edge (the next-state value). Therefore the display equals the live count in all non-LAP modes.
- On entering LAP, the display freezes at the live value from the last non-LAP edge.
- On leaving LAP for RUN, the display jumps to the current live value on the first edge.
- `running` is registered: it equals (`state` == RUN or LAP), one cycle after `state`.
- `wrap` is registered and is high only for the cycle following the rollover edge.
- Arithmetic is unsigned with no saturation. Out-of-range values cannot occur from reset.

## Timing
- `state` is sampled on every rising edge; no handshake is used. A state change takes effect on the same edge it is sampled.
- From RUN entry to the first `cs` increment: CLK_DIV edges when `pre` was 0 (after STOP); fewer after PAUSE, because the partial prescaler phase is retained.
- STOP → RUN → STOP within one tick period leaves the count at 00:00.00.
- Transitions between RUN and LAP, in either direction, do not disturb `pre` or the live count.
- PAUSE → STOP clears everything on the next edge, regardless of `pre`.
- If a tick coincides with a change into PAUSE or STOP, the new state wins: no increment occurs.
- The output path is registered only; there is no combinational path from `state` to `disp_*`.

## Structure
- Shared package `sw_pkg`:
  - State encodings `ST_STOP`, `ST_RUN`, `ST_LAP`, `ST_PAUSE`, used by both the FSM and this block.
  - Limits `CS_MAX`=99 and `SM_MAX`=59.
- Sub-module `sw_prescaler`:
  - Ports: `clk`, `rst_n`, `en`, `clr`, output `tick`; parameterized by CLK_DIV/DIV_W.
  - `clr` has priority over `en`.
- Top of block: the cascaded BCD-free binary counters, the display hold registers, and the `running`/`wrap` flags.

## Test plan
Use CLK_DIV=4 throughout.
- Reset then RUN for 40 cycles → `disp` = 00:00.10, `running`=1; `rst_n` low mid-count → all outputs 0 asynchronously.
- Preload via RUN to 00:59.99, then one more tick → 01:00.00 in a single edge; `wrap` stays 0.
- Run to 59:59.99, then one tick → 00:00.00 and `wrap` high for exactly one cycle.
- RUN to 00:00.05, then LAP for 20 cycles → `disp` stays 00:00.05; return to RUN → `disp` shows 00:00.10 on the first edge.
- RUN 6 cycles (`pre`=2), PAUSE 50 cycles (no change), RUN → the next tick arrives after 2 cycles.
- PAUSE at 00:01.23, then STOP → `disp` = 00:00.00 next edge, `running`=0; tick coinciding with the PAUSE entry edge → no increment.
